// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared control-unit types: FSM states, RV32I opcodes,
//               ALU operation and register-file write-source encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } cu_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Encoding is {funct7_5, funct3} so R/I-type decode is a direct mapping.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [1:0] RU_SRC_ALU = 2'b00;
  localparam logic [1:0] RU_SRC_DM  = 2'b01;
  localparam logic [1:0] RU_SRC_PC4 = 2'b10;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_dec
// Description : Maps opcode/funct3/funct7_5 to an ALU operation; everything
//               outside R/I-type arithmetic uses ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_dec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op
);

  logic w_is_op;
  logic w_is_op_imm;

  assign w_is_op     = (opcode == OPC_OP);
  assign w_is_op_imm = (opcode == OPC_OP_IMM);

  always_comb begin
    alu_op = ALU_ADD;
    if (w_is_op || w_is_op_imm) begin
      case (funct3)
        // instr[30] is an immediate bit for ADDI, so SUB only exists in R-type
        3'b000: alu_op = (w_is_op && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op = ALU_SLL;
        3'b010: alu_op = ALU_SLT;
        3'b011: alu_op = ALU_SLTU;
        3'b100: alu_op = ALU_XOR;
        3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_op = ALU_OR;
        3'b111: alu_op = ALU_AND;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_cu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_cu
// Description : Multicycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//               with a memory-wait watchdog. Define CU_PERF_CNT_EN to add
//               cycle_cnt / retired_cnt performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cu
  import rv32i_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        aluASrc,
  output logic        aluBSrc,
  output logic        ru_wr,
  output logic        dm_req,
  output logic        dm_wr,
  output logic        im_req,
  output logic        instr_done,
  output logic        trap,
  output logic [3:0]  aluOp,
  output logic [1:0]  ru_data_src
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  cu_state_e        r_state;
  cu_state_e        w_next;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic             r_funct7_5;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;
  alu_op_e          w_alu_op;

  logic w_is_load, w_is_store, w_is_branch, w_is_op;
  logic w_is_auipc, w_is_jal, w_is_jalr;

  assign w_is_load   = (r_opcode == OPC_LOAD);
  assign w_is_store  = (r_opcode == OPC_STORE);
  assign w_is_branch = (r_opcode == OPC_BRANCH);
  assign w_is_op     = (r_opcode == OPC_OP);
  assign w_is_auipc  = (r_opcode == OPC_AUIPC);
  assign w_is_jal    = (r_opcode == OPC_JAL);
  assign w_is_jalr   = (r_opcode == OPC_JALR);

  // Counter holds the number of mem_ready=0 cycles already spent in this state.
  assign w_timeout = !mem_ready && (r_wait_cnt == CNT_W'(WAIT_MAX - 1));

  alu_op_dec u_alu_op_dec (
    .opcode   (r_opcode),
    .funct3   (r_funct3),
    .funct7_5 (r_funct7_5),
    .alu_op   (w_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7_5 <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (r_state == S_DECODE) begin
        r_opcode   <= opcode;
        r_funct3   <= funct3;
        r_funct7_5 <= funct7_5;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    aluASrc     = 1'b0;
    aluBSrc     = 1'b0;
    ru_wr       = 1'b0;
    dm_req      = 1'b0;
    dm_wr       = 1'b0;
    im_req      = 1'b0;
    instr_done  = 1'b0;
    trap        = 1'b0;
    aluOp       = ALU_ADD;
    ru_data_src = RU_SRC_ALU;
    // While reset is held every control output stays quiet.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          im_req = 1'b1;
          if (mem_ready) begin
            ir_wr  = 1'b1;
            w_next = S_DECODE;
          end else if (w_timeout) begin
            w_next = S_TRAP;
          end
        end
        S_DECODE: w_next = is_rv32i_opcode(opcode) ? S_EXEC : S_TRAP;
        S_EXEC: begin
          aluASrc = w_is_auipc || w_is_jal || w_is_branch;
          aluBSrc = !(w_is_op || w_is_branch);
          aluOp   = w_alu_op;
          if (w_is_load || w_is_store) begin
            w_next = S_MEM;
          end else if (w_is_branch) begin
            pc_wr      = branch_taken;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_wr  = w_is_store;
          if (mem_ready) begin
            if (w_is_store) begin
              pc_wr      = 1'b1;
              instr_done = 1'b1;
              w_next     = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end else if (w_timeout) begin
            w_next = S_TRAP;
          end
        end
        S_WB: begin
          ru_wr       = 1'b1;
          pc_wr       = 1'b1;
          instr_done  = 1'b1;
          ru_data_src = (w_is_jal || w_is_jalr) ? RU_SRC_PC4 :
                        (w_is_load ? RU_SRC_DM : RU_SRC_ALU);
          w_next      = S_FETCH;
        end
        S_TRAP:  trap = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef CU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_cu
// Description : Directed bench for multicycle_cu; per-instruction expected
//               cycle sequences are queued and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cu;
  import rv32i_pkg::*;

  localparam int WAIT_MAX = 15;
  localparam logic [6:0] JUNK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, branch_taken, mem_ready;
  logic       ir_wr, pc_wr, aluASrc, aluBSrc, ru_wr, dm_req, dm_wr, im_req;
  logic       instr_done, trap;
  logic [3:0] aluOp;
  logic [1:0] ru_data_src;
`ifdef CU_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_cu #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .aluASrc(aluASrc), .aluBSrc(aluBSrc),
    .ru_wr(ru_wr), .dm_req(dm_req), .dm_wr(dm_wr), .im_req(im_req),
    .instr_done(instr_done), .trap(trap), .aluOp(aluOp), .ru_data_src(ru_data_src)
`ifdef CU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f75;
    logic        taken;
    logic        rdy;
    logic [15:0] exp;
    int          id;
    bit          start;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_id = -1;
  int   done_at[32];

  // {ir_wr,pc_wr,aluASrc,aluBSrc,ru_wr,dm_req,dm_wr,im_req,instr_done,trap,aluOp,ru_data_src}
  function automatic logic [15:0] ex(input bit ir, input bit pc, input bit as, input bit bs,
                                     input bit ru, input bit dq, input bit dw, input bit iq,
                                     input bit dn, input bit tr, input logic [3:0] op,
                                     input logic [1:0] src);
    return {ir, pc, as, bs, ru, dq, dw, iq, dn, tr, op, src};
  endfunction

  task automatic push(input bit r, input logic [6:0] o, input logic [2:0] f, input logic s,
                      input logic tk, input logic rd, input logic [15:0] e, input bit st);
    rec_t x;
    x.rst = r; x.opc = o; x.f3 = f; x.f75 = s; x.taken = tk; x.rdy = rd;
    x.exp = e; x.id = cur_id; x.start = st;
    q.push_back(x);
  endtask

  task automatic push_reset(input int n);
    cur_id = -1;
    for (int i = 0; i < n; i++) push(1, JUNK, 3'b111, 1'b1, 1'b1, 1'b1, 16'h0000, 0);
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++)
      push(0, JUNK, 3'b111, 1'b1, 1'b1, 1'b1, ex(0,0,0,0,0,0,0,0,0,1,ALU_ADD,RU_SRC_ALU), 0);
  endtask

  // Expected behaviour of one instruction from its class; abort stops after
  // mlat MEM cycles without mem_ready (used for reset/timeout cases).
  task automatic push_instr(input int id, input logic [6:0] o, input logic [2:0] f,
                            input logic s, input logic tk, input int flat, input int mlat,
                            input logic [3:0] op, input bit abort);
    bit ld, sw, br, jmp, as, bs, last;
    logic [1:0] src;
    ld  = (o == OPC_LOAD);
    sw  = (o == OPC_STORE);
    br  = (o == OPC_BRANCH);
    jmp = (o == OPC_JAL) || (o == OPC_JALR);
    as  = (o == OPC_AUIPC) || (o == OPC_JAL) || br;
    bs  = !((o == OPC_OP) || br);
    cur_id = id;
    for (int i = 0; i < flat; i++) begin
      last = (i == flat - 1);
      push(0, JUNK, 3'b111, 1'b1, 1'b1, last, ex(last,0,0,0,0,0,0,1,0,0,ALU_ADD,RU_SRC_ALU), i == 0);
    end
    push(0, o, f, s, 1'b1, 1'b1, 16'h0000, 0);
    push(0, JUNK, 3'b111, 1'b1, br ? tk : 1'b1, 1'b1,
         ex(0, br && tk, as, bs, 0, 0, 0, 0, br, 0, op, RU_SRC_ALU), 0);
    if (ld || sw) begin
      for (int i = 0; i < mlat; i++) begin
        last = !abort && (i == mlat - 1);
        push(0, JUNK, 3'b111, 1'b1, 1'b1, last,
             ex(0, sw && last, 0, 0, 0, 1, sw, 0, sw && last, 0, ALU_ADD, RU_SRC_ALU), 0);
      end
    end
    if (abort || br || sw) return;
    src = jmp ? RU_SRC_PC4 : (ld ? RU_SRC_DM : RU_SRC_ALU);
    push(0, JUNK, 3'b111, 1'b1, 1'b1, 1'b1, ex(0,1,0,0,1,0,0,0,1,0,ALU_ADD,src), 0);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] act;
    int          cyc_in;
    bit          perf_ok;
    int          m_cyc, m_ret;
    cyc_in = 0; perf_ok = 0; m_cyc = 0; m_ret = 0;
    for (int i = 0; i < 32; i++) done_at[i] = -1;
    rst = 1'b1; opcode = JUNK; funct3 = 3'b000; funct7_5 = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b0;

    push_reset(2);
    push_instr(0,  OPC_OP,     3'b000, 1'b0, 1'b1, 1, 0, ALU_ADD,  0); // ADD x3,x1,x2
    push_instr(1,  OPC_OP,     3'b000, 1'b1, 1'b1, 1, 0, ALU_SUB,  0);
    push_instr(2,  OPC_OP_IMM, 3'b101, 1'b1, 1'b1, 2, 0, ALU_SRA,  0);
    push_instr(3,  OPC_OP_IMM, 3'b000, 1'b1, 1'b1, 1, 0, ALU_ADD,  0); // ADDI, imm bit 10 set
    push_instr(4,  OPC_OP,     3'b111, 1'b0, 1'b1, 1, 0, ALU_AND,  0);
    push_instr(5,  OPC_OP_IMM, 3'b100, 1'b0, 1'b1, 1, 0, ALU_XOR,  0);
    push_instr(6,  OPC_OP,     3'b011, 1'b0, 1'b1, 1, 0, ALU_SLTU, 0);
    push_instr(7,  OPC_OP,     3'b001, 1'b0, 1'b1, 1, 0, ALU_SLL,  0);
    push_instr(8,  OPC_OP,     3'b101, 1'b0, 1'b1, 1, 0, ALU_SRL,  0);
    push_instr(9,  OPC_AUIPC,  3'b101, 1'b1, 1'b1, 1, 0, ALU_ADD,  0);
    push_instr(10, OPC_LUI,    3'b111, 1'b0, 1'b1, 1, 0, ALU_ADD,  0);
    push_instr(11, OPC_JAL,    3'b110, 1'b1, 1'b1, 1, 0, ALU_ADD,  0);
    push_instr(12, OPC_JALR,   3'b000, 1'b0, 1'b1, 1, 0, ALU_ADD,  0);
    push_instr(13, OPC_LOAD,   3'b010, 1'b0, 1'b1, 1, 3, ALU_ADD,  0); // LW, dmem ready after 3
    push_instr(14, OPC_LOAD,   3'b010, 1'b0, 1'b1, 3, 1, ALU_ADD,  0);
    push_instr(15, OPC_STORE,  3'b010, 1'b0, 1'b1, 1, 1, ALU_ADD,  0); // SW
    push_instr(16, OPC_BRANCH, 3'b000, 1'b0, 1'b0, 1, 0, ALU_ADD,  0); // BEQ not taken
    push_instr(17, OPC_BRANCH, 3'b000, 1'b0, 1'b1, 1, 0, ALU_ADD,  0); // BEQ taken
    push_instr(18, OPC_LOAD,   3'b010, 1'b0, 1'b1, WAIT_MAX, WAIT_MAX, ALU_ADD, 0);
    push_instr(19, OPC_STORE,  3'b010, 1'b0, 1'b1, 1, 2, ALU_ADD,  1); // reset mid-MEM
    push_reset(1);
    push_instr(20, OPC_OP,     3'b000, 1'b0, 1'b1, 1, 0, ALU_ADD,  0);
    cur_id = 21;                                                      // illegal opcode
    push(0, JUNK, 3'b000, 1'b0, 1'b1, 1'b1, ex(1,0,0,0,0,0,0,1,0,0,ALU_ADD,RU_SRC_ALU), 1);
    push(0, 7'h7F, 3'b000, 1'b0, 1'b1, 1'b1, 16'h0000, 0);
    push_trap(4);
    push_reset(1);
    cur_id = 22;                                                      // FETCH wait timeout
    for (int i = 0; i < WAIT_MAX; i++)
      push(0, JUNK, 3'b111, 1'b1, 1'b1, 1'b0, ex(0,0,0,0,0,0,0,1,0,0,ALU_ADD,RU_SRC_ALU), i == 0);
    push_trap(4);
    push_reset(1);
    push_instr(23, OPC_LOAD,   3'b010, 1'b0, 1'b1, 1, WAIT_MAX, ALU_ADD, 1); // MEM timeout
    push_trap(3);
    push_reset(1);
    push_instr(24, OPC_OP,     3'b110, 1'b0, 1'b1, 1, 0, ALU_OR,   0);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst = q[i].rst; opcode = q[i].opc; funct3 = q[i].f3; funct7_5 = q[i].f75;
      branch_taken = q[i].taken; mem_ready = q[i].rdy;
      if (q[i].start) cyc_in = 0;
      cyc_in++;
      @(negedge clk);
      act = {ir_wr, pc_wr, aluASrc, aluBSrc, ru_wr, dm_req, dm_wr, im_req,
             instr_done, trap, aluOp, ru_data_src};
      checks++;
      if (act !== q[i].exp) begin
        failures++;
        $display("FAIL ctrl rec=%0d id=%0d got=%h expected=%h", i, q[i].id, act, q[i].exp);
      end
      if (instr_done === 1'b1 && q[i].id >= 0) done_at[q[i].id] = cyc_in;
`ifdef CU_PERF_CNT_EN
      if (perf_ok) begin
        checks++;
        if (cycle_cnt !== m_cyc || retired_cnt !== m_ret) begin
          failures++;
          $display("FAIL perf rec=%0d got=%0d/%0d expected=%0d/%0d",
                   i, cycle_cnt, retired_cnt, m_cyc, m_ret);
        end
      end
      if (q[i].rst) begin
        m_cyc = 0; m_ret = 0; perf_ok = 1;
      end else begin
        m_cyc++;
        m_ret += int'(q[i].exp[7]);
      end
`endif
    end

    // Hand-computed retirement cycles (cycle 1 = first FETCH cycle)
    chk_int("add_done_cycle",      done_at[0],  4);
    chk_int("auipc_done_cycle",    done_at[9],  4);
    chk_int("lw_mem3_done_cycle",  done_at[13], 7);
    chk_int("lw_fetch3_done_cycle", done_at[14], 7);
    chk_int("sw_done_cycle",       done_at[15], 4);
    chk_int("beq_nt_done_cycle",   done_at[16], 3);
    chk_int("beq_t_done_cycle",    done_at[17], 3);
    chk_int("lw_wait_max_done",    done_at[18], 2 * WAIT_MAX + 3);
    chk_int("sw_aborted_no_done",  done_at[19], -1);
    chk_int("illegal_no_done",     done_at[21], -1);
    chk_int("final_or_done_cycle", done_at[24], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, giving the max cycles to wait on mem_ready before trapping.
REQ-002 SHALL have port clk  in  1  single clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port opcode  in  7  instr[6:0] from instruction register.
REQ-005 SHALL have port funct3  in  3  instr[14:12].
REQ-006 SHALL have port funct7_5  in  1  instr[30].
REQ-007 SHALL have port branch_taken  in  1  branch-unit compare result, valid in EXEC.
REQ-008 SHALL have port mem_ready  in  1  memory handshake done (imem or dmem).
REQ-009 SHALL have outputs ir_wr, pc_wr, aluASrc, aluBSrc, ru_wr, dm_req, dm_wr, im_req, instr_done, trap, each out 1.
REQ-010 SHALL have ports aluOp out 4 (ALU operation) and ru_data_src out 2 (00 ALU, 01 DM, 10 PC+4).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs decoded combinationally from state plus the latched opcode/funct fields.
REQ-012 SHALL, in FETCH, assert im_req and stay until mem_ready=1; on that cycle assert ir_wr and go to DECODE.
REQ-013 SHALL, in DECODE, latch opcode/funct3/funct7_5, go to TRAP if the opcode is not an RV32I opcode, otherwise go to EXEC.
REQ-014 SHALL drive aluASrc=1 (PC) in EXEC for AUIPC, JAL and BRANCH and aluASrc=0 (rs1) otherwise; aluBSrc=1 (imm) for all but R-type and BRANCH.
REQ-015 SHALL derive aluOp from funct3/funct7_5 for R/I-type ALU ops and force ADD for loads, stores, AUIPC, JAL, JALR and LUI.
REQ-016 SHALL route EXEC to: MEM for LOAD/STORE; FETCH for BRANCH, asserting pc_wr only if branch_taken; WB for all others.
REQ-017 SHALL, in MEM, assert dm_req (dm_wr=1 for STORE) until mem_ready; then LOAD goes to WB, and STORE asserts pc_wr plus instr_done and goes to FETCH.
REQ-018 SHALL, in WB, assert ru_wr, pc_wr and instr_done for exactly one cycle, select ru_data_src per class (JAL/JALR=10, LOAD=01, else 00), then go to FETCH.
REQ-019 SHALL treat instr_done as a one-cycle pulse per retired instruction, including taken and not-taken branches in EXEC.
REQ-020 SHALL count wait cycles in FETCH/MEM, clearing the counter on state entry; reaching WAIT_MAX with mem_ready=0 goes to TRAP.
REQ-021 SHALL hold TRAP with trap=1 and all write/request outputs 0 until rst.
REQ-022 SHALL give mem_ready=1 on the first cycle of FETCH/MEM a total latency of 1 cycle in that state.
REQ-023 SHALL have a minimum CPI of 3 (branch), 4 (ALU/store), 5 (load).

Reset
REQ-024 SHALL, with rst=1 at a clk edge, enter FETCH, clear the wait counter and latched fields, and force all outputs 0 and aluOp=ADD the following cycle, including mid-MEM.
REQ-025 SHALL give rst priority over mem_ready and over TRAP.

Configuration
REQ-026 SHALL, with CU_PERF_CNT_EN defined, add outputs cycle_cnt out 32 and retired_cnt out 32, both cleared by rst and wrapping at 2^32; retired_cnt increments on instr_done.
REQ-027 SHALL, without CU_PERF_CNT_EN, omit these ports and counters entirely.

Structure
REQ-028 SHALL take the state enum, RV32I opcode constants, aluOp encodings and ru_data_src encodings from shared package rv32i_pkg.
REQ-029 SHALL place aluOp decoding in sub-module alu_op_dec (opcode, funct3, funct7_5 -> aluOp).

Verification
REQ-030 SHALL cover: ADD x3,x1,x2 with mem_ready on the first cycle -> FETCH,DECODE,EXEC,WB; aluASrc=0, aluBSrc=0, ru_wr pulse in cycle 4.
REQ-031 SHALL cover: AUIPC -> aluASrc=1, aluBSrc=1, aluOp=ADD, ru_data_src=00.
REQ-032 SHALL cover: LW with dmem mem_ready after 3 cycles -> MEM lasts 3 cycles, ru_data_src=01, instr_done at cycle 7.
REQ-033 SHALL cover: BEQ with branch_taken=0, then with branch_taken=1 -> pc_wr 0 then 1 in EXEC, both return to FETCH after 3 cycles.
REQ-034 SHALL cover: opcode 7'h7F, and separately mem_ready held 0 for 15 cycles in FETCH -> trap=1, outputs 0 until rst.
REQ-035 SHALL cover: rst pulse during MEM of SW -> dm_req=0 the next cycle, state FETCH, perf counters 0 (with CU_PERF_CNT_EN).
